// File: rtl/mux_pkg.sv
// Shared widths, pin-bus field offsets and enums for the mux pin sequencer.
package mux_pkg;
    localparam int IW_W   = 18;
    localparam int OW_W   = 24;
    localparam int DATA_W = 16;
    localparam int IW_CLK = 0;
    localparam int IW_RST = 1;
    localparam int IW_UI  = 2;
    localparam int IW_UIO = 10;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_STEP   = 2'd1,
        OP_RESET  = 2'd2,
        OP_SELECT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_SETTLE,
        ST_RESP
    } state_e;
endpackage

// File: rtl/mux_ow_select.sv
// Picks one project's 24-bit ow word from the concatenated bus; zero when sel is out of range.
module mux_ow_select
    import mux_pkg::*;
#(
    parameter int NUM_PROJ = 16,
    parameter int SEL_W    = 4
) (
    input  logic [NUM_PROJ*OW_W-1:0] ow_bus,
    input  logic [SEL_W-1:0]         sel,
    output logic [OW_W-1:0]          word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (sel == SEL_W'(i)) word = ow_bus[i*OW_W +: OW_W];
        end
    end

endmodule

// File: rtl/mux_pin_sequencer.sv
// Host-side sequencer for the shared project pin bus: applies commands to iw/ena,
// pulses proj_clk, then returns a registered sample of the selected project's ow.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | cmd_ready high, waiting for a command
//   ST_APPLY  | new iw/ena just driven, one cycle before any clock pulse
//   ST_CLK_HI | proj_clk high for CLK_HALF cycles
//   ST_CLK_LO | proj_clk low for CLK_HALF cycles; loops while pulses remain
//   ST_SETTLE | waiting SETTLE cycles before sampling ow
//   ST_RESP   | response held until rsp_ready
module mux_pin_sequencer
    import mux_pkg::*;
#(
    parameter int NUM_PROJ = 16,
    parameter int SEL_W    = 4,
    parameter int SETTLE   = 2,
    parameter int CLK_HALF = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [SEL_W-1:0]         cmd_sel,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic [7:0]               cmd_count,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OW_W-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [NUM_PROJ-1:0]      ena,
    output logic [IW_W-1:0]          iw,
    input  logic [NUM_PROJ*OW_W-1:0] ow_bus,
    output logic                     busy
);

    localparam logic [7:0]       HALF_LD   = 8'(CLK_HALF - 1);
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [SEL_W:0]   NUM_PROJ_W = (SEL_W+1)'(NUM_PROJ);

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [SEL_W-1:0]      sel_q;
    logic [7:0]            cnt_q;
    logic [7:0]            tmr_q;
    logic                  tmr_done;
    logic                  accept;
    logic                  sel_ok;
    logic [NUM_PROJ-1:0]   ena_dec;
    logic [OW_W-1:0]       ow_word;

    assign tmr_done  = (tmr_q == 8'd0);
    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign sel_ok    = ({1'b0, cmd_sel} < NUM_PROJ_W);

    always_comb begin
        ena_dec = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (cmd_sel == SEL_W'(i)) ena_dec[i] = 1'b1;
        end
    end

    mux_ow_select #(.NUM_PROJ(NUM_PROJ), .SEL_W(SEL_W)) u_ow_select (
        .ow_bus (ow_bus),
        .sel    (sel_q),
        .word   (ow_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_APPLY;
            ST_APPLY:  state_d = (cnt_q != 8'd0) ? ST_CLK_HI : ST_SETTLE;
            ST_CLK_HI: if (tmr_done) state_d = ST_CLK_LO;
            ST_CLK_LO: if (tmr_done) state_d = (cnt_q != 8'd0) ? ST_CLK_HI : ST_SETTLE;
            ST_SETTLE: if (tmr_done) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_WRITE;
            sel_q     <= '0;
            cnt_q     <= 8'd0;
            tmr_q     <= 8'd0;
            iw        <= '0;
            ena       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (!tmr_done) tmr_q <= tmr_q - 8'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= op_e'(cmd_op);
                        rsp_err <= 1'b0;
                        cnt_q   <= 8'd0;
                        unique case (op_e'(cmd_op))
                            OP_WRITE: iw[IW_W-1:IW_UI] <= cmd_data;
                            OP_STEP: begin
                                iw[IW_W-1:IW_UI] <= cmd_data;
                                cnt_q            <= cmd_count;
                            end
                            OP_RESET: begin
                                iw[IW_RST] <= 1'b0;
                                cnt_q      <= (cmd_count == 8'd0) ? 8'd1 : cmd_count;
                            end
                            OP_SELECT: begin
                                iw[IW_W-1:IW_UI] <= '0;
                                sel_q            <= cmd_sel;
                                ena              <= sel_ok ? ena_dec : '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_APPLY: begin
                    if (cnt_q != 8'd0) begin
                        iw[IW_CLK] <= 1'b1;
                        tmr_q      <= HALF_LD;
                    end else begin
                        tmr_q <= SETTLE_LD;
                    end
                end
                ST_CLK_HI: begin
                    if (tmr_done) begin
                        iw[IW_CLK] <= 1'b0;
                        tmr_q      <= HALF_LD;
                        if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                        // proj_rst_n is released together with the last falling clock edge
                        if (op_q == OP_RESET && cnt_q <= 8'd1) iw[IW_RST] <= 1'b1;
                    end
                end
                ST_CLK_LO: begin
                    if (tmr_done) begin
                        if (cnt_q != 8'd0) begin
                            iw[IW_CLK] <= 1'b1;
                            tmr_q      <= HALF_LD;
                        end else begin
                            tmr_q <= SETTLE_LD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= (ena != '0) ? ow_word : '0;
                        rsp_err   <= (op_q == OP_SELECT) && (ena == '0);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pin_sequencer.sv
// Randomized bench for mux_pin_sequencer against a command-level reference model.
module tb_mux_pin_sequencer;

    localparam int NP = 12;
    localparam int SW = 4;
    localparam int ST = 2;
    localparam int CH = 1;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SW-1:0]     cmd_sel;
    logic [15:0]       cmd_data;
    logic [7:0]        cmd_count;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [23:0]       rsp_data;
    logic              rsp_err;
    logic [NP-1:0]     ena;
    logic [17:0]       iw;
    logic [NP*24-1:0]  ow_bus;
    logic              busy;

    logic [23:0] ow_words [NP];

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] m_data;
    logic        m_rst;
    int          m_sel;
    bit          m_err;

    mux_pin_sequencer #(.NUM_PROJ(NP), .SEL_W(SW), .SETTLE(ST), .CLK_HALF(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ena       (ena),
        .iw        (iw),
        .ow_bus    (ow_bus),
        .busy      (busy)
    );

    always_comb begin
        ow_bus = '0;
        for (int i = 0; i < NP; i++) ow_bus[i*24 +: 24] = ow_words[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ena();
        return (m_sel < 0) ? 32'd0 : (32'd1 << m_sel);
    endfunction

    function automatic logic [31:0] exp_rsp();
        return (m_sel < 0) ? 32'd0 : {8'd0, ow_words[m_sel]};
    endfunction

    function automatic logic [31:0] exp_iw();
        return {14'd0, m_data, m_rst, 1'b0};
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_rst  = 1'b0;
        m_sel  = -1;
        m_err  = 1'b0;
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val("ack_valid_drop", rsp_valid, 0);
        check_val("ack_ready_rise", cmd_ready, 1);
        check_val("ack_err_kept", rsp_err, m_err);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [SW-1:0] sel, input logic [15:0] data,
                           input logic [7:0] count, input int hold, input bit ack);
        int p, lat, rises, highs, rlow, n;
        logic prev;
        logic [31:0] iw0;
        p = 0;
        m_err = 1'b0;
        case (op)
            2'd0: m_data = data;
            2'd1: begin m_data = data; p = int'(count); end
            2'd2: p = (count == 8'd0) ? 1 : int'(count);
            default: begin
                m_data = '0;
                m_err  = (int'(sel) >= NP);
                m_sel  = m_err ? -1 : int'(sel);
            end
        endcase
        iw0 = {14'd0, m_data, (op == 2'd2) ? 1'b0 : m_rst, 1'b0};

        @(negedge clk);
        cmd_op = op; cmd_sel = sel; cmd_data = data; cmd_count = count;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_before_cmd", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_val("iw_apply", iw, iw0);
        check_val("ena_apply", ena, exp_ena());
        check_val("busy_apply", busy, 1);

        prev  = iw[0];
        highs = iw[0] ? 1 : 0;
        rlow  = iw[1] ? 0 : 1;
        rises = 0;
        lat   = 0;
        while (!rsp_valid && lat < 700) begin
            @(posedge clk);
            #1;
            lat++;
            if (iw[0] && !prev) rises++;
            if (iw[0]) highs++;
            if (!iw[1]) rlow++;
            prev = iw[0];
        end
        if (op == 2'd2) m_rst = 1'b1;

        check_val("latency", lat, 1 + 2*CH*p + ST);
        check_val("clk_pulses", rises, p);
        check_val("clk_high_cycles", highs, p*CH);
        if (op == 2'd2) check_val("rst_low_cycles", rlow, 1 + CH*(2*p - 1));
        check_val("iw_final", iw, exp_iw());
        check_val("rsp_data", rsp_data, exp_rsp());
        check_val("rsp_err", rsp_err, m_err);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", rsp_valid, 1);
            check_val("hold_data", rsp_data, exp_rsp());
            check_val("hold_err", rsp_err, m_err);
            check_val("hold_not_ready", cmd_ready, 0);
        end
        if (ack) ack_rsp();
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0;
        cmd_data = '0; cmd_count = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NP; i++) ow_words[i] = 24'($urandom);
        model_reset();

        // commands offered during reset must not reach the pin bus
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_iw", iw, 0);
        check_val("rst_ena", ena, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        run_cmd(2'd0, 4'd0, 16'hA55A, 8'd0, 0, 1);
        check_val("write_a55a_iw", iw, 32'h29568);

        ow_words[3] = 24'h123456;
        run_cmd(2'd3, 4'd3, 16'h0000, 8'd0, 0, 1);
        check_val("sel3_ena", ena, 32'h0008);
        check_val("sel3_data", rsp_data, 32'h123456);

        run_cmd(2'd1, 4'd0, 16'h1234, 8'd5, 0, 1);
        run_cmd(2'd2, 4'd0, 16'h0000, 8'd0, 0, 1);
        run_cmd(2'd3, 4'd15, 16'h0000, 8'd0, 0, 1);
        check_val("sel15_ena", ena, 0);
        check_val("sel15_err", rsp_err, 1);

        run_cmd(2'd3, 4'd7, 16'h0000, 8'd0, 0, 1);
        run_cmd(2'd0, 4'd0, 16'hBEEF, 8'd0, 10, 1);

        // response handshake and new command in the same cycle
        run_cmd(2'd0, 4'd0, 16'h1234, 8'd0, 0, 0);
        @(negedge clk);
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h0F0F; cmd_count = 8'd0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val("ovl_rsp_drop", rsp_valid, 0);
        check_val("ovl_cmd_waits", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        m_data = 16'h0F0F;
        check_val("ovl_cmd_taken", busy, 1);
        check_val("ovl_iw", iw, exp_iw());
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("ovl_latency", lat, 1 + ST);
        check_val("ovl_rsp_data", rsp_data, exp_rsp());
        ack_rsp();

        for (int k = 0; k < 40; k++) begin
            logic [1:0] op;
            logic [7:0] cnt;
            op  = 2'($urandom_range(0, 3));
            cnt = ($urandom_range(0, 9) == 0) ? 8'd20 : 8'($urandom_range(0, 6));
            for (int i = 0; i < NP; i++) ow_words[i] = 24'($urandom);
            run_cmd(op, 4'($urandom_range(0, 15)), 16'($urandom), cnt, $urandom_range(0, 3), 1);
        end

        // async reset in the middle of a long STEP
        run_cmd(2'd3, 4'd2, 16'h0000, 8'd0, 0, 1);
        @(negedge clk);
        cmd_op = 2'd1; cmd_data = 16'hC3C3; cmd_count = 8'd20; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_iw", iw, 0);
        check_val("abort_ena", ena, 0);
        check_val("abort_rsp_valid", rsp_valid, 0);
        check_val("abort_rsp_data", rsp_data, 0);
        check_val("abort_rsp_err", rsp_err, 0);
        check_val("abort_cmd_ready", cmd_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(2'd0, 4'd0, 16'h5A5A, 8'd0, 0, 1);
        run_cmd(2'd3, 4'd11, 16'h0000, 8'd0, 0, 1);
        run_cmd(2'd1, 4'd0, 16'h8001, 8'd3, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
